countdown_timer: RTL

- Minutes:seconds down-counter; the count-down counterpart of the team's up-counting seconds/minutes stopwatch chain.
- Software or a front panel loads a preset MM:SS. The block decrements once per external 1 Hz enable tick while running.
- When it reaches 00:00 it emits a one-cycle expiry pulse and holds a done flag.
- Sits beside the stopwatch counters and shares the same tick source and display path.

---
 rtl/countdown_timer_if.sv | 38 +++
 rtl/countdown_timer.sv | 109 ++++++++++
 2 files changed

// File: rtl/countdown_timer_if.sv
// countdown_timer_if
//   Control and status bundle for the MM:SS countdown timer.
//   master : panel/software side, drives the controls and preset, reads status.
//   slave  : timer side, consumes the controls, drives the count and flags.
//   Signals:
//     tick          one-cycle enable pulse (nominally 1 Hz)
//     clear         return to 00:00 / IDLE
//     load          capture load_min/load_sec as the new count
//     load_min/sec  preset value (clamped inside the timer)
//     start/stop    resume / pause counting
//     minutes/sec   registered count
//     running       RUN state decode
//     done          EXPIRED state decode
//     expired_tick  one-cycle pulse when the count reaches 00:00
interface countdown_timer_if;
  logic       tick;
  logic       clear;
  logic       load;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       stop;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       done;
  logic       expired_tick;

  modport master (
    output tick, clear, load, load_min, load_sec, start, stop,
    input  minutes, seconds, running, done, expired_tick
  );

  modport slave (
    input  tick, clear, load, load_min, load_sec, start, stop,
    output minutes, seconds, running, done, expired_tick
  );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer
//   Minutes:seconds down-counter. Decrements once per tick while running,
//   pulses expired_tick and holds done when it reaches 00:00.
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous active-high reset, wins over every other input
//     bus  countdown_timer_if.slave (controls in, count/flags out)
//
//   state   | meaning
//   --------+-------------------------------------------
//   IDLE    | loaded or zero, not counting
//   RUN     | counting on tick
//   PAUSED  | halted with a nonzero count
//   EXPIRED | reached 00:00, holds done until load/clear
module countdown_timer #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic              clk,
  input  logic              rst,
  countdown_timer_if.slave  bus
);

  localparam logic [5:0] MAX_MIN_V = 6'(MAX_MIN);
  localparam logic [5:0] SEC_MAX   = 6'd59;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t     state;
  logic [5:0] min_q;
  logic [5:0] sec_q;
  logic       running_q;
  logic       done_q;
  logic       exp_q;

  logic [5:0] pre_min;
  logic [5:0] pre_sec;
  logic       pre_zero;
  logic       cnt_zero;
  logic       last_sec;

  always_comb begin
    pre_min  = (bus.load_min > MAX_MIN_V) ? MAX_MIN_V : bus.load_min;
    pre_sec  = (bus.load_sec > SEC_MAX)   ? SEC_MAX   : bus.load_sec;
    pre_zero = (pre_min == 6'd0) && (pre_sec == 6'd0);
    cnt_zero = (min_q == 6'd0) && (sec_q == 6'd0);
    // The decrement that lands on 00:00 starts from 00:01.
    last_sec = (min_q == 6'd0) && (sec_q == 6'd1);
  end

  // Priority: rst > clear > load > stop > start > tick. A stop or start
  // consumes the cycle, so a coincident tick is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      exp_q     <= 1'b0;
    end else begin
      exp_q <= 1'b0;
      if (bus.clear) begin
        state     <= IDLE;
        min_q     <= 6'd0;
        sec_q     <= 6'd0;
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else if (bus.load) begin
        min_q     <= pre_min;
        sec_q     <= pre_sec;
        running_q <= 1'b0;
        done_q    <= 1'b0;
        // A paused timer stays paused across a nonzero reload.
        if (!pre_zero && state == PAUSED) state <= PAUSED;
        else                              state <= IDLE;
      end else if (bus.stop) begin
        if (state == RUN) begin
          state     <= PAUSED;
          running_q <= 1'b0;
        end
      end else if (bus.start) begin
        if ((state == IDLE || state == PAUSED) && !cnt_zero) begin
          state     <= RUN;
          running_q <= 1'b1;
        end
      end else if (bus.tick && state == RUN) begin
        if (sec_q != 6'd0) begin
          sec_q <= sec_q - 6'd1;
        end else begin
          sec_q <= SEC_MAX;
          min_q <= min_q - 6'd1;
        end
        if (last_sec) begin
          state     <= EXPIRED;
          running_q <= 1'b0;
          done_q    <= 1'b1;
          exp_q     <= 1'b1;
        end
      end
    end
  end

  assign bus.minutes      = min_q;
  assign bus.seconds      = sec_q;
  assign bus.running      = running_q;
  assign bus.done         = done_q;
  assign bus.expired_tick = exp_q;

endmodule
